// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and DEPTH-entry prefetch FIFO in front of a 1-cycle sync ROM.
// Optional FETCH_BYPASS_EN: forward the returning word straight to out_* while the FIFO is empty.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              ROM_AW   = 14,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000,
   parameter int              DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ROM_AW-1:0]      imem_addr,
   input  logic [XLEN-1:0]        imem_data,
   input  logic                   redirect_valid,
   input  logic [XLEN-1:0]        redirect_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_pc,
   output logic [XLEN-1:0]        out_iword,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] tag_q, tag_d;
   logic            inflight_q, inflight_d;
   ptr_t            rd_ptr_q, rd_ptr_d;
   ptr_t            wr_ptr_q, wr_ptr_d;
   cnt_t            count_q, count_d;
   logic [XLEN-1:0] pc_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_d [DEPTH];
   logic [XLEN-1:0] iw_mem_q [DEPTH];
   logic [XLEN-1:0] iw_mem_d [DEPTH];

   logic [XLEN-1:0] redir_pc;
   logic            fifo_empty;
   logic            fifo_pop;
   logic            byp_vld;
   logic            byp_take;
   logic            push;
   logic            issue;
   cnt_t            occ;
   logic            unused_bits;

   assign redir_pc    = {redirect_pc[XLEN-1:2], 2'b00};
   assign fifo_empty  = (count_q == '0);
   assign fifo_count  = count_q;
   assign unused_bits = ^redirect_pc[1:0];

   // Handshake, push and issue decisions; occ is occupancy once this cycle settles
   always_comb begin
      byp_vld  = 1'b0;
      byp_take = 1'b0;
      fifo_pop = ~fifo_empty & out_ready;
`ifdef FETCH_BYPASS_EN
      byp_vld  = fifo_empty & inflight_q & ~redirect_valid;
      byp_take = byp_vld & out_ready;
`endif
      push  = inflight_q & ~redirect_valid & ~byp_take;
      occ   = count_q + cnt_t'(push) - cnt_t'(fifo_pop);
      issue = (occ < cnt_t'(DEPTH));
   end

   // Head of queue, or the returning word when it is bypassed
   always_comb begin
      out_valid = ~fifo_empty | byp_vld;
      out_pc    = pc_mem_q[rd_ptr_q];
      out_iword = iw_mem_q[rd_ptr_q];
      if (byp_vld) begin
         out_pc    = tag_q;
         out_iword = imem_data;
      end
   end

   // ROM address: reset vector, redirect target, or next sequential pc
   always_comb begin
      if (rst)
         imem_addr = RESET_PC[ROM_AW+1:2];
      else if (redirect_valid)
         imem_addr = redirect_pc[ROM_AW+1:2];
      else
         imem_addr = fetch_pc_q[ROM_AW+1:2];
   end

   // Fetch pc and in-flight tracking; a redirect replaces any in-flight request
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      tag_d      = tag_q;
      inflight_d = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = redir_pc + XLEN'(4);
         tag_d      = redir_pc;
         inflight_d = 1'b1;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
         tag_d      = fetch_pc_q;
         inflight_d = 1'b1;
      end
   end

   // FIFO pointers, count and storage; a redirect flushes everything
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pc_mem_d = pc_mem_q;
      iw_mem_d = iw_mem_q;
      if (redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q] = tag_q;
            iw_mem_d[wr_ptr_q] = imem_data;
            wr_ptr_d           = wr_ptr_q + ptr_t'(1);
         end
         if (fifo_pop)
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
         count_d = occ;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         pc_mem_q   <= '{default: '0};
         iw_mem_q   <= '{default: '0};
      end else begin
         fetch_pc_q <= fetch_pc_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         pc_mem_q   <= pc_mem_d;
         iw_mem_q   <= iw_mem_d;
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end with a prefetch buffer for the pipelined core. It replaces the bare pc_IF register and +4 logic.
- Drives the synchronous instruction ROM (1-cycle read latency) and buffers fetched {pc, iword} pairs in a DEPTH-entry FIFO.
- Presents them to the ID stage over a valid/ready handshake.
- Accepts branch redirects from EX, flushing buffered and in-flight fetches.

Parameters:
- XLEN, 32, width of PC and instruction word.
- ROM_AW, 14, ROM word-address width; imem_addr = pc[ROM_AW+1:2].
- RESET_PC, 32'h8000, fetch address after reset.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_addr  out  ROM_AW  ROM word address, registered by the ROM at the clk edge.
- imem_data  in  XLEN  ROM read data, valid the cycle after the address is presented.
- redirect_valid  in  1  branch/jump taken in EX, single-cycle pulse.
- redirect_pc  in  XLEN  new fetch target; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  ID stage accepts the head this cycle.
- out_pc  out  XLEN  PC of the head entry.
- out_iword  out  XLEN  instruction word of the head entry.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, inflight=0, FIFO empty, fifo_count=0, out_valid=0, out_pc=0, out_iword=0. While rst=1, imem_addr = RESET_PC word address.
- State: fetch_pc (next address to request), inflight flag with a tag PC (request issued last cycle), FIFO read pointer, write pointer and count.
- pop = out_valid & out_ready. FIFO head is combinational from registered storage; out_valid = (count != 0).
- Issue rule when there is no redirect: issue when (count + inflight - pop) < DEPTH.
  - On issue: imem_addr = fetch_pc word address, fetch_pc <= fetch_pc + 4 (wraps mod 2^XLEN), inflight <= 1, tag <= fetch_pc.
  - On no issue: imem_addr holds fetch_pc, fetch_pc is unchanged, inflight <= 0.
- Return: when inflight=1, imem_data is pushed with the tag PC at the end of that cycle. Push and pop in the same cycle leave count unchanged.
- Latency: request issued in cycle N, data on imem_data in N+1, out_valid with that entry in N+2.
- Throughput: with out_ready held at 1, one instruction per cycle in steady state for any DEPTH of 2 or more.
- Redirect (priority over everything else):
  - FIFO is flushed (count <= 0, pointers reset).
  - The inflight return arriving next cycle is discarded: inflight is cleared and replaced by the new request.
  - imem_addr = {redirect_pc[XLEN-1:2],2'b00} word address is issued in the same cycle.
  - fetch_pc <= aligned redirect_pc + 4; inflight <= 1; tag <= aligned redirect_pc.
  - First redirected instruction appears on out_valid 2 cycles after the redirect cycle.
- A handshake (pop) in the redirect cycle counts as completed for the consumer; the entry is removed with the flush.
- Back-to-back redirects: the latest one wins; the earlier target's return is discarded.
- FIFO full with out_ready=0: no issue. The inflight entry still lands, guaranteed by the issue rule, so the FIFO never overflows and no fetch is lost.
- Empty with out_ready=1: out_valid=0 and there is no pop; ready is ignored.
- imem_addr wraps within the ROM space by truncation.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty, inflight=1 and there is no redirect, the returning imem_data/tag are driven directly on out_iword/out_pc with out_valid=1.
  - If out_ready=1, the entry is consumed and not pushed; otherwise it is pushed.
  - Latency becomes N+1 and redirect-to-first-instruction becomes 1 cycle.
- Undefined: out_* come only from FIFO storage; latency is N+2 as above.

Test Plan:
- Reset release with RESET_PC=32'h8000, out_ready=1, ROM word k = k → out_pc 8000,8004,8008... on consecutive cycles from cycle 2; out_iword = 32'h2000, 32'h2001....
- out_ready=0 for 10 cycles, DEPTH=4 → fifo_count saturates at 4; imem_addr frozen; releasing ready gives pcs contiguous with no gap or duplicate.
- redirect_valid pulse with redirect_pc=32'h8103 while FIFO holds 3 entries → fifo_count=0 next cycle; next out_pc=32'h8100 exactly 2 cycles after the pulse; stale pcs never appear.
- Redirects on two consecutive cycles to 32'h8200 then 32'h8300 → first delivered out_pc is 32'h8300, followed by 32'h8304.
- Alternating out_ready 1/0 for 100 cycles → delivered PC sequence strictly +4 and matches the ROM model; fifo_count never exceeds DEPTH.
- Assert rst for 1 cycle mid-stream with a full FIFO → out_valid=0 immediately (asynchronous); fetch restarts at 32'h8000; with FETCH_BYPASS_EN defined, first out_valid is 1 cycle earlier.
